// File: rtl/correlation_accumulator.sv
// Window accumulator behind correlation_cell: sums I, I^2 and T_j*I over
// WINDOW_LEN accepted samples and hands each window's sums to the divider through
// a one-entry valid/ready output register. The next window accumulates while the
// previous result waits.
module correlation_accumulator #(
  parameter int PIXEL_SIZE    = 8,
  parameter int NUM_TEMPLATES = 10,
  parameter int WINDOW_LEN    = 64,
  localparam int CNT_W = $clog2(WINDOW_LEN),
  localparam int SI_W  = PIXEL_SIZE + $clog2(WINDOW_LEN + 1),
  localparam int SQ_W  = 2 * PIXEL_SIZE + $clog2(WINDOW_LEN + 1)
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic                                         clear,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [PIXEL_SIZE-1:0]                        I_in,
  input  logic [2*PIXEL_SIZE-1:0]                      I_square_in,
  input  logic [NUM_TEMPLATES-1:0][2*PIXEL_SIZE-1:0]   T_x_I_in,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [SI_W-1:0]                              sum_I,
  output logic [SQ_W-1:0]                              sum_I2,
  output logic [NUM_TEMPLATES-1:0][SQ_W-1:0]           sum_TI,
  output logic [CNT_W-1:0]                             sample_cnt
);

  logic [CNT_W-1:0]                     sample_cnt_q, sample_cnt_d;
  logic [SI_W-1:0]                      acc_i_q, acc_i_d;
  logic [SQ_W-1:0]                      acc_i2_q, acc_i2_d;
  logic [NUM_TEMPLATES-1:0][SQ_W-1:0]   acc_ti_q, acc_ti_d;
  logic [SI_W-1:0]                      sum_i_q, sum_i_d;
  logic [SQ_W-1:0]                      sum_i2_q, sum_i2_d;
  logic [NUM_TEMPLATES-1:0][SQ_W-1:0]   sum_ti_q, sum_ti_d;
  logic                                 out_valid_q, out_valid_d;

  // Running sums including the sample currently on the inputs
  logic [SI_W-1:0]                      i_plus;
  logic [SQ_W-1:0]                      i2_plus;
  logic [NUM_TEMPLATES-1:0][SQ_W-1:0]   ti_plus;

  logic last_sample;
  logic accept;

  assign last_sample = (sample_cnt_q == CNT_W'(WINDOW_LEN - 1));

  // Only the closing sample of a window has to wait for the output slot to free up;
  // out_ready feeds straight through so a consumer read frees it in the same cycle.
  assign in_ready = !clear && !(last_sample && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;

  assign i_plus  = acc_i_q + SI_W'(I_in);
  assign i2_plus = acc_i2_q + SQ_W'(I_square_in);

  generate
    for (genvar gi = 0; gi < NUM_TEMPLATES; gi++) begin : g_lane
      assign ti_plus[gi] = acc_ti_q[gi] + SQ_W'(T_x_I_in[gi]);
    end
  endgenerate

  // Next-state: window counter, accumulators and the output register
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    acc_i_d      = acc_i_q;
    acc_i2_d     = acc_i2_q;
    acc_ti_d     = acc_ti_q;
    sum_i_d      = sum_i_q;
    sum_i2_d     = sum_i2_q;
    sum_ti_d     = sum_ti_q;
    out_valid_d  = out_valid_q && !out_ready;

    if (clear) begin
      sample_cnt_d = '0;
      acc_i_d      = '0;
      acc_i2_d     = '0;
      acc_ti_d     = '0;
    end else if (accept) begin
      if (last_sample) begin
        sum_i_d      = i_plus;
        sum_i2_d     = i2_plus;
        sum_ti_d     = ti_plus;
        out_valid_d  = 1'b1;
        sample_cnt_d = '0;
        acc_i_d      = '0;
        acc_i2_d     = '0;
        acc_ti_d     = '0;
      end else begin
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
        acc_i_d      = i_plus;
        acc_i2_d     = i2_plus;
        acc_ti_d     = ti_plus;
      end
    end
  end

  // State registers; reset drops both the partial window and any held result
  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_cnt_q <= '0;
      acc_i_q      <= '0;
      acc_i2_q     <= '0;
      acc_ti_q     <= '0;
      sum_i_q      <= '0;
      sum_i2_q     <= '0;
      sum_ti_q     <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      acc_i_q      <= acc_i_d;
      acc_i2_q     <= acc_i2_d;
      acc_ti_q     <= acc_ti_d;
      sum_i_q      <= sum_i_d;
      sum_i2_q     <= sum_i2_d;
      sum_ti_q     <= sum_ti_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign out_valid  = out_valid_q;
  assign sum_I      = sum_i_q;
  assign sum_I2     = sum_i2_q;
  assign sum_TI     = sum_ti_q;

endmodule

// File: tb/tb_correlation_accumulator.sv
// Bench for correlation_accumulator with a 4-sample window: directed windows push
// hand-computed sums into a queue, and a monitor pops and compares on every
// output handshake.
module tb_correlation_accumulator;
  localparam int PS  = 8;
  localparam int NT  = 10;
  localparam int WL  = 4;
  localparam int CW  = $clog2(WL);
  localparam int SIW = PS + $clog2(WL + 1);
  localparam int SQW = 2 * PS + $clog2(WL + 1);

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       clear;
  logic                       in_valid;
  logic                       in_ready;
  logic [PS-1:0]              i_in;
  logic [2*PS-1:0]            i_sq_in;
  logic [NT-1:0][2*PS-1:0]    txi_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [SIW-1:0]             sum_i;
  logic [SQW-1:0]             sum_i2;
  logic [NT-1:0][SQW-1:0]     sum_ti;
  logic [CW-1:0]              sample_cnt;

  correlation_accumulator #(
    .PIXEL_SIZE(PS), .NUM_TEMPLATES(NT), .WINDOW_LEN(WL)
  ) dut (
    .CLK(clk), .RST(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .I_in(i_in), .I_square_in(i_sq_in), .T_x_I_in(txi_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_I(sum_i), .sum_I2(sum_i2), .sum_TI(sum_ti),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int si;
    int si2;
    int sti[NT];
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_cycles = 0;
  int   window_no = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // sum_TI[j] expectation is ti_base*j when per_lane, else ti_base for every lane
  task automatic push_exp(input int si, input int si2, input int ti_base, input bit per_lane);
    exp_t e;
    e.si  = si;
    e.si2 = si2;
    for (int j = 0; j < NT; j++) e.sti[j] = per_lane ? ti_base * j : ti_base;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int i, input int isq, input int t, input bit per_lane);
    in_valid = 1'b1;
    i_in     = PS'(i);
    i_sq_in  = (2*PS)'(isq);
    for (int j = 0; j < NT; j++) txi_in[j] = (2*PS)'(per_lane ? t * j : t);
  endtask

  // Present one sample and return #1 after the edge that accepted it; in_valid stays up
  task automatic send(input int i, input int isq, input int t, input bit per_lane);
    int waited;
    waited = 0;
    drive(i, isq, t, per_lane);
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      stall_cycles++;
      if (waited > 50) begin
        check("send_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Monitor: every output handshake consumes one expected window
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=sum_I %0d required=no result", sum_i);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        window_no++;
        $display("window %0d: sum_I=%0d sum_I2=%0d sum_TI[9]=%0d", window_no, sum_i, sum_i2, sum_ti[NT-1]);
        check("sum_I", int'(sum_i), e.si);
        check("sum_I2", int'(sum_i2), e.si2);
        for (int j = 0; j < NT; j++) check($sformatf("sum_TI[%0d]", j), int'(sum_ti[j]), e.sti[j]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    i_in = '0; i_sq_in = '0; txi_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sample_cnt", int'(sample_cnt), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sum_I", int'(sum_i), 0);
    check("rst_sum_I2", int'(sum_i2), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // 1: basic window, result one cycle after the 4th accept, single-cycle pulse
    push_exp(10, 30, 10, 1'b1);
    for (int k = 1; k <= 4; k++) send(k, k * k, k, 1'b1);
    idle();
    check("t1_latency_valid", int'(out_valid), 1);
    check("t1_latency_sum_I", int'(sum_i), 10);
    check("t1_cnt_wrap", int'(sample_cnt), 0);
    @(posedge clk); #1;
    check("t1_pulse_end", int'(out_valid), 0);

    // 2: maximum values, no wrap
    push_exp(1020, 260100, 260100, 1'b0);
    repeat (4) send(255, 65025, 65025, 1'b0);
    idle();
    @(posedge clk); #1;

    // 3: backpressure; only the closing sample of window 2 stalls
    out_ready = 1'b0;
    push_exp(4, 4, 4, 1'b0);
    repeat (4) send(1, 1, 1, 1'b0);
    push_exp(8, 16, 16, 1'b0);
    stall_cycles = 0;
    repeat (3) send(2, 4, 4, 1'b0);
    check("t3_early_no_stall", stall_cycles, 0);
    check("t3_cnt_3", int'(sample_cnt), 3);
    drive(2, 4, 4, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("t3_stall_in_ready", int'(in_ready), 0);
      check("t3_held_sum_I", int'(sum_i), 4);
      check("t3_held_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_release_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    idle();
    check("t3_reload_valid", int'(out_valid), 1);
    check("t3_reload_sum_I", int'(sum_i), 8);
    @(posedge clk); #1;
    check("t3_drained", int'(out_valid), 0);

    // 4: back-to-back windows with continuous in_valid
    stall_cycles = 0;
    repeat (3) push_exp(4, 4, 4, 1'b0);
    for (int k = 0; k < 12; k++) begin
      send(1, 1, 1, 1'b0);
      check($sformatf("t4_pulse_%0d", k), int'(out_valid), (k % 4 == 3) ? 1 : 0);
    end
    idle();
    check("t4_never_stalled", stall_cycles, 0);
    @(posedge clk); #1;

    // 5: clear discards the partial window and the sample offered with it
    send(5, 25, 5, 1'b0);
    send(5, 25, 5, 1'b0);
    drive(9, 81, 9, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    check("t5_clear_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    idle();
    check("t5_clear_cnt", int'(sample_cnt), 0);
    check("t5_clear_keeps_valid", int'(out_valid), 0);
    push_exp(4, 4, 4, 1'b0);
    repeat (4) send(1, 1, 1, 1'b0);
    idle();
    @(posedge clk); #1;

    // 6: reset mid-window
    send(7, 49, 7, 1'b0);
    send(7, 49, 7, 1'b0);
    idle();
    check("t6_cnt_before", int'(sample_cnt), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_rst_cnt", int'(sample_cnt), 0);
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_sum_I", int'(sum_i), 0);
    check("t6_rst_sum_I2", int'(sum_i2), 0);
    push_exp(12, 36, 12, 1'b1);
    for (int k = 0; k < 4; k++) send(3, 9, 3, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("all_windows_seen", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
